// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage MIPS pipeline.
// Performs lw/sw against an internal word-addressed data memory with
// MEM_WAIT wait states. It registers the write-back bundle and requests an
// upstream stall while an access is in flight.
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   Alu_result          byte address for lw/sw, or the ALU value for R-type/addi
//   Instruction_MEM     instruction from execute (32'd0 is a bubble)
//   Write_data_mem      store data for sw
//   Instruction_WB      instruction forwarded to write-back
//   Wb_data/Wb_reg/Wb_en register-file write bundle
//   addr_err            one-cycle pulse with a completed access to a bad address
//   stall               combinational hold request to upstream stages
module mem_stage #(
  parameter int DEPTH    = 64,
  parameter int MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Alu_result,
  input  logic [31:0] Instruction_MEM,
  input  logic [31:0] Write_data_mem,
  output logic [31:0] Instruction_WB,
  output logic [31:0] Wb_data,
  output logic [4:0]  Wb_reg,
  output logic        Wb_en,
  output logic        addr_err,
  output logic        stall
);
  localparam int       AW = $clog2(DEPTH);
  localparam logic [3:0] MW = 4'(MEM_WAIT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic [31:0]     mem [DEPTH];

  logic [5:0]      op, funct;
  logic            is_lw, is_sw, is_mem, bad, complete, rtype_ok;
  logic [AW-1:0]   idx;
  logic [4:0]      wb_reg_d;
  logic [31:0]     wb_data_d;
  logic            we_d;

  assign op     = Instruction_MEM[31:26];
  assign funct  = Instruction_MEM[5:0];
  assign is_lw  = (op == 6'd35);
  assign is_sw  = (op == 6'd43);
  assign is_mem = is_lw | is_sw;
  assign idx    = Alu_result[AW+1:2];
  assign bad    = (|Alu_result[1:0]) | (|Alu_result[31:AW+2]);
  assign rtype_ok = (op == 6'd0) &&
                    (funct == 6'b100000 || funct == 6'b100010 || funct == 6'b100100 ||
                     funct == 6'b100101 || funct == 6'b101010);

  // Wait-state sequencing. 'complete' marks the edge that samples the inputs,
  // performs the access and loads the real write-back bundle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem && MW != 4'd0) begin
          stall     = 1'b1;
          state_nxt = WAIT;
          cnt_nxt   = 4'd1;
        end else begin
          complete  = 1'b1;
        end
      end
      WAIT: begin
        if (cnt < MW) begin
          stall   = 1'b1;
          cnt_nxt = cnt + 4'd1;
        end else begin
          complete  = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Held in reset the FSM is IDLE and nothing is in flight, so no stall.
    if (!reset) stall = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Write-back decode; a bad lw returns 0 but still writes the register.
  always_comb begin
    wb_reg_d  = 5'd0;
    wb_data_d = 32'd0;
    we_d      = 1'b0;
    if (rtype_ok) begin
      wb_reg_d  = Instruction_MEM[15:11];
      wb_data_d = Alu_result;
      we_d      = 1'b1;
    end else if (op == 6'd8) begin
      wb_reg_d  = Instruction_MEM[20:16];
      wb_data_d = Alu_result;
      we_d      = 1'b1;
    end else if (is_lw) begin
      wb_reg_d  = Instruction_MEM[20:16];
      wb_data_d = bad ? 32'd0 : mem[idx];
      we_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Instruction_WB <= 32'd0;
      Wb_data        <= 32'd0;
      Wb_reg         <= 5'd0;
      Wb_en          <= 1'b0;
      addr_err       <= 1'b0;
    end else if (complete) begin
      Instruction_WB <= Instruction_MEM;
      Wb_data        <= wb_data_d;
      Wb_reg         <= wb_reg_d;
      Wb_en          <= we_d && (wb_reg_d != 5'd0);
      addr_err       <= is_mem && bad;
    end else begin
      Instruction_WB <= 32'd0;
      Wb_data        <= 32'd0;
      Wb_reg         <= 5'd0;
      Wb_en          <= 1'b0;
      addr_err       <= 1'b0;
    end
  end

  // Reset clears every word, so the array is built from flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (complete && is_sw && !bad) begin
      mem[idx] <= Write_data_mem;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: one instance with MEM_WAIT=2 (d=0) and one with
// MEM_WAIT=0 (d=1), both DEPTH=64, driven by directed and random ops and
// compared against a transaction-level model.
module tb_mem_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] alu [2], ins [2], wd [2];
  logic [31:0] iwb [2], wbd [2];
  logic [4:0]  wbr [2];
  logic        wbe [2], aerr [2], stl [2];

  mem_stage #(.DEPTH(64), .MEM_WAIT(2)) dut_w (
    .clk(clk), .reset(reset), .Alu_result(alu[0]), .Instruction_MEM(ins[0]),
    .Write_data_mem(wd[0]), .Instruction_WB(iwb[0]), .Wb_data(wbd[0]),
    .Wb_reg(wbr[0]), .Wb_en(wbe[0]), .addr_err(aerr[0]), .stall(stl[0]));

  mem_stage #(.DEPTH(64), .MEM_WAIT(0)) dut_z (
    .clk(clk), .reset(reset), .Alu_result(alu[1]), .Instruction_MEM(ins[1]),
    .Write_data_mem(wd[1]), .Instruction_WB(iwb[1]), .Wb_data(wbd[1]),
    .Wb_reg(wbr[1]), .Wb_en(wbe[1]), .addr_err(aerr[1]), .stall(stl[1]));

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [2][64];
  logic [5:0]  fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_i(input int op, input int rt, input int imm);
    logic [5:0] o = 6'(op);
    logic [4:0] t = 5'(rt);
    return {o, 5'd1, t, 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_r(input int rd, input logic [5:0] fn);
    logic [4:0] r = 5'(rd);
    return {6'd0, 5'd1, 5'd2, r, 5'd0, fn};
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 64; k++) ref_mem[d][k] = 32'd0;
  endtask

  // Present one op on instance d (called #1 after a rising edge), follow it
  // through its stall cycles, and check the completed bundle.
  task automatic run_op(input int d, input logic [31:0] i, input logic [31:0] a,
                        input logic [31:0] w);
    logic [5:0]  op;
    logic        memop, bad, e_en;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    int          nst;
    op     = i[31:26];
    memop  = (op == 6'd35) || (op == 6'd43);
    bad    = (a[1:0] != 2'd0) || (a[31:8] != 24'd0);
    e_reg  = 5'd0;
    e_data = 32'd0;
    e_en   = 1'b0;
    if (op == 6'd0 && (i[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a})) begin
      e_reg = i[15:11]; e_data = a; e_en = 1'b1;
    end else if (op == 6'd8) begin
      e_reg = i[20:16]; e_data = a; e_en = 1'b1;
    end else if (op == 6'd35) begin
      e_reg = i[20:16]; e_data = bad ? 32'd0 : ref_mem[d][a[7:2]]; e_en = 1'b1;
    end
    if (e_reg == 5'd0) e_en = 1'b0;
    nst = (memop && d == 0) ? 2 : 0;

    ins[d] = i; alu[d] = a; wd[d] = w;
    #1;
    for (int k = 0; k < nst; k++) begin
      chk("stall_hi", 32'(stl[d]), 32'd1);
      @(posedge clk); #1;
      chk("bubble_iwb", iwb[d], 32'd0);
      chk("bubble_en", 32'(wbe[d]), 32'd0);
      chk("bubble_err", 32'(aerr[d]), 32'd0);
    end
    chk("stall_lo", 32'(stl[d]), 32'd0);
    @(posedge clk); #1;
    if (op == 6'd43 && !bad) ref_mem[d][a[7:2]] = w;
    chk("iwb", iwb[d], i);
    chk("wb_reg", 32'(wbr[d]), 32'(e_reg));
    chk("wb_data", wbd[d], e_data);
    chk("wb_en", 32'(wbe[d]), 32'(e_en));
    chk("addr_err", 32'(aerr[d]), 32'(memop && bad));
    ins[d] = 32'd0; alu[d] = 32'd0; wd[d] = 32'd0;
  endtask

  task automatic rand_op(output logic [31:0] i, output logic [31:0] a);
    int kind, sel;
    kind = $urandom_range(0, 9);
    sel  = $urandom_range(0, 9);
    if (sel < 7)       a = {24'd0, 4'($urandom_range(0, 15)), 2'b00};
    else if (sel == 7) a = {24'd0, 6'($urandom), 2'($urandom_range(1, 3))};
    else if (sel == 8) a = {22'($urandom_range(1, 1023)), 8'($urandom) & 8'hfc, 2'b00};
    else               a = $urandom;
    case (kind)
      0, 1: i = enc_r($urandom_range(0, 31), fn_tab[$urandom_range(0, 4)]);
      2:    i = enc_r($urandom_range(0, 31), 6'($urandom));
      3:    i = enc_i(8, $urandom_range(0, 31), $urandom);
      4, 5: i = enc_i(35, $urandom_range(0, 31), $urandom);
      6, 7: i = enc_i(43, $urandom_range(0, 31), $urandom);
      8:    i = {6'($urandom_range(2, 5)), 26'($urandom)};
      default: i = ($urandom_range(0, 1) != 0) ? 32'd0 : $urandom;
    endcase
  endtask

  initial begin
    logic [31:0] ri, ra;
    for (int d = 0; d < 2; d++) begin
      alu[d] = 32'd0; ins[d] = 32'd0; wd[d] = 32'd0;
    end
    clear_model();

    // Reset state
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_iwb", iwb[d], 32'd0);
      chk("rst_data", wbd[d], 32'd0);
      chk("rst_reg", 32'(wbr[d]), 32'd0);
      chk("rst_en", 32'(wbe[d]), 32'd0);
      chk("rst_err", 32'(aerr[d]), 32'd0);
      chk("rst_stall", 32'(stl[d]), 32'd0);
    end
    #10 reset = 1'b1;
    @(posedge clk); #1;

    // Store then load, R-type, addi to $0
    run_op(0, enc_i(43, 4, 16), 32'h10, 32'hDEADBEEF);
    run_op(0, enc_i(35, 5, 16), 32'h10, 32'd0);
    run_op(0, enc_r(3, 6'h20), 32'd7, 32'd0);
    run_op(0, enc_i(8, 0, 5), 32'd5, 32'd0);
    // Bad addresses; 0x10 must keep its value after the misaligned store
    run_op(0, enc_i(43, 4, 17), 32'h11, 32'h55555555);
    run_op(0, enc_i(35, 6, 16), 32'h10, 32'd0);
    run_op(0, enc_i(35, 9, 1024), 32'h400, 32'd0);
    // Branch and bubble pass-through
    run_op(0, {6'd4, 5'd1, 5'd2, 16'h0003}, 32'h10, 32'h12345678);
    run_op(0, 32'd0, 32'h10, 32'h12345678);
    run_op(0, enc_i(35, 7, 16), 32'h10, 32'd0);
    // Zero-wait build: back-to-back sw/lw at 0x4
    run_op(1, enc_i(43, 4, 4), 32'h4, 32'hCAFEF00D);
    run_op(1, enc_i(35, 2, 4), 32'h4, 32'd0);

    // Random traffic on both instances
    for (int n = 0; n < 400; n++) begin
      rand_op(ri, ra);
      run_op(n % 2, ri, ra, $urandom);
    end

    // Reset mid-WAIT with a store to 8 pending
    run_op(0, enc_i(43, 4, 8), 32'h8, 32'h0BADF00D);
    ins[0] = enc_i(43, 4, 8); alu[0] = 32'h8; wd[0] = 32'h11112222;
    #1;
    chk("pre_rst_stall", 32'(stl[0]), 32'd1);
    @(posedge clk); #1;
    chk("wait_stall", 32'(stl[0]), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_iwb", iwb[0], 32'd0);
    chk("mid_rst_data", wbd[0], 32'd0);
    chk("mid_rst_reg", 32'(wbr[0]), 32'd0);
    chk("mid_rst_en", 32'(wbe[0]), 32'd0);
    chk("mid_rst_err", 32'(aerr[0]), 32'd0);
    chk("mid_rst_stall", 32'(stl[0]), 32'd0);
    @(posedge clk); #1;
    ins[0] = 32'd0; alu[0] = 32'd0; wd[0] = 32'd0;
    reset = 1'b1;
    clear_model();
    @(posedge clk); #1;
    run_op(0, enc_i(35, 7, 8), 32'h8, 32'd0);
    run_op(0, enc_i(35, 8, 16), 32'h10, 32'd0);
    run_op(1, enc_i(35, 3, 4), 32'h4, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
